// File: rtl/gcode_pkg.sv
// Shared types for the G-code modal sequencer: command codes, sequencer
// states and the bit positions inside the modal_state output word.
package gcode_pkg;

  typedef enum logic [3:0] {
    G00 = 4'd0,
    G01 = 4'd1,
    G20 = 4'd2,
    G21 = 4'd3,
    G90 = 4'd4,
    G91 = 4'd5,
    M2  = 4'd6,
    M6  = 4'd7,
    M72 = 4'd8
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_TOOL,
    S_HALT
  } state_e;

  localparam int MS_LINEAR   = 0;
  localparam int MS_INCHES   = 1;
  localparam int MS_ABSOLUTE = 2;
  localparam int MS_RAISE    = 3;
  localparam int MS_TOOLCHG  = 4;

endpackage

// File: rtl/coord_scaler.sv
// One axis of target computation: optional inch-to-mm scaling, optional
// relative accumulation onto the current position, then saturation to
// the position range with an overflow flag. Purely combinational.
module coord_scaler #(
  parameter int COORD_W    = 16,
  parameter int POS_W      = 20,
  parameter int INCH_NUM   = 813,
  parameter int INCH_SHIFT = 5
) (
  input  logic signed [COORD_W-1:0] op_i,
  input  logic signed [POS_W-1:0]   pos_i,
  input  logic                      inches_i,
  input  logic                      absolute_i,
  output logic signed [POS_W-1:0]   tgt_o,
  output logic                      sat_o
);

  // The sum is kept wide enough that neither the scaled operand nor the
  // accumulation can wrap before the saturation compare sees it.
  localparam int NUM_W  = $clog2(INCH_NUM + 1) + 1;
  localparam int PROD_W = COORD_W + NUM_W;
  localparam int SUM_W  = ((PROD_W > POS_W) ? PROD_W : POS_W) + 1;
  localparam logic signed [SUM_W-1:0] POS_MAX = SUM_W'((64'sd1 <<< (POS_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] POS_MIN = SUM_W'(-(64'sd1 <<< (POS_W - 1)));

  logic signed [PROD_W-1:0] opWide;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] scaled;
  logic signed [SUM_W-1:0]  sum;

  // Scale, accumulate and clamp the target for this axis.
  always_comb begin
    opWide = PROD_W'(op_i);
    prod   = opWide * PROD_W'(INCH_NUM);
    scaled = inches_i ? (prod >>> INCH_SHIFT) : opWide;
    sum    = absolute_i ? SUM_W'(scaled) : (SUM_W'(scaled) + SUM_W'(pos_i));
    tgt_o  = sum[POS_W-1:0];
    sat_o  = 1'b0;
    if (sum > POS_MAX) begin
      tgt_o = POS_MAX[POS_W-1:0];
      sat_o = 1'b1;
    end else if (sum < POS_MIN) begin
      tgt_o = POS_MIN[POS_W-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/gcode_modal_sequencer.sv
// Handshaked G-code sequencer: accepts decoded commands, keeps the modal
// state, tracks the absolute XY position and issues motion, tool-change
// and program-end sequences.
module gcode_modal_sequencer
  import gcode_pkg::*;
#(
  parameter int COORD_W    = 16,
  parameter int POS_W      = 20,
  parameter int INCH_NUM   = 813,
  parameter int INCH_SHIFT = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [3:0]                cmd_code_i,
  input  logic signed [COORD_W-1:0] cmd_x_i,
  input  logic signed [COORD_W-1:0] cmd_y_i,
  output logic                      mv_valid_o,
  input  logic                      mv_ready_i,
  output logic                      mv_linear_o,
  output logic                      mv_pen_up_o,
  output logic signed [POS_W-1:0]   mv_x_o,
  output logic signed [POS_W-1:0]   mv_y_o,
  output logic                      tool_req_o,
  input  logic                      tool_ack_i,
  output logic [4:0]                modal_state_o,
  output logic                      halted_o,
  output logic                      err_o
);

  state_e                    state_q;
  logic                      cmdReady_q;
  logic                      linear_q;
  logic                      inches_q;
  logic                      absolute_q;
  logic                      raise_q;
  logic                      toolChg_q;
  logic                      mvValid_q;
  logic                      mvLinear_q;
  logic                      mvPenUp_q;
  logic                      toolReq_q;
  logic                      halted_q;
  logic                      err_q;
  logic signed [COORD_W-1:0] opX_q;
  logic signed [COORD_W-1:0] opY_q;
  logic signed [POS_W-1:0]   posX_q;
  logic signed [POS_W-1:0]   posY_q;
  logic signed [POS_W-1:0]   tgtX_d;
  logic signed [POS_W-1:0]   tgtY_d;
  logic                      satX_d;
  logic                      satY_d;

  coord_scaler #(
    .COORD_W(COORD_W), .POS_W(POS_W), .INCH_NUM(INCH_NUM), .INCH_SHIFT(INCH_SHIFT)
  ) u_scaleX (
    .op_i(opX_q), .pos_i(posX_q), .inches_i(inches_q), .absolute_i(absolute_q),
    .tgt_o(tgtX_d), .sat_o(satX_d)
  );

  coord_scaler #(
    .COORD_W(COORD_W), .POS_W(POS_W), .INCH_NUM(INCH_NUM), .INCH_SHIFT(INCH_SHIFT)
  ) u_scaleY (
    .op_i(opY_q), .pos_i(posY_q), .inches_i(inches_q), .absolute_i(absolute_q),
    .tgt_o(tgtY_d), .sat_o(satY_d)
  );

  // Sequencer FSM; every output is a register updated here. The move
  // target doubles as the tracked position, so mv_x/mv_y mirror pos.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmdReady_q <= 1'b1;
      linear_q   <= 1'b0;
      inches_q   <= 1'b0;
      absolute_q <= 1'b1;
      raise_q    <= 1'b0;
      toolChg_q  <= 1'b0;
      mvValid_q  <= 1'b0;
      mvLinear_q <= 1'b0;
      mvPenUp_q  <= 1'b0;
      toolReq_q  <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
      opX_q      <= '0;
      opY_q      <= '0;
      posX_q     <= '0;
      posY_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            case (cmd_code_i)
              G20: inches_q   <= 1'b1;
              G21: inches_q   <= 1'b0;
              G90: absolute_q <= 1'b1;
              G91: absolute_q <= 1'b0;
              M72: raise_q    <= 1'b1;
              G00, G01: begin
                linear_q   <= (cmd_code_i == G01);
                toolChg_q  <= 1'b0;
                opX_q      <= cmd_x_i;
                opY_q      <= cmd_y_i;
                state_q    <= S_CALC;
                cmdReady_q <= 1'b0;
              end
              M6: begin
                toolChg_q  <= 1'b1;
                toolReq_q  <= 1'b1;
                state_q    <= S_TOOL;
                cmdReady_q <= 1'b0;
              end
              M2: begin
                halted_q   <= 1'b1;
                state_q    <= S_HALT;
                cmdReady_q <= 1'b0;
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        S_CALC: begin
          posX_q     <= tgtX_d;
          posY_q     <= tgtY_d;
          mvLinear_q <= linear_q;
          mvPenUp_q  <= raise_q;
          mvValid_q  <= 1'b1;
          if (satX_d || satY_d) begin
            err_q <= 1'b1;
          end
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (mv_ready_i) begin
            mvValid_q  <= 1'b0;
            raise_q    <= 1'b0;
            state_q    <= S_IDLE;
            cmdReady_q <= 1'b1;
          end
        end
        S_TOOL: begin
          if (tool_ack_i) begin
            toolReq_q  <= 1'b0;
            toolChg_q  <= 1'b0;
            state_q    <= S_IDLE;
            cmdReady_q <= 1'b1;
          end
        end
        S_HALT: state_q <= S_HALT;
        default: begin
          state_q    <= S_IDLE;
          cmdReady_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready_o = cmdReady_q;
  assign mv_valid_o  = mvValid_q;
  assign mv_linear_o = mvLinear_q;
  assign mv_pen_up_o = mvPenUp_q;
  assign mv_x_o      = posX_q;
  assign mv_y_o      = posY_q;
  assign tool_req_o  = toolReq_q;
  assign halted_o    = halted_q;
  assign err_o       = err_q;

  assign modal_state_o[MS_LINEAR]   = linear_q;
  assign modal_state_o[MS_INCHES]   = inches_q;
  assign modal_state_o[MS_ABSOLUTE] = absolute_q;
  assign modal_state_o[MS_RAISE]    = raise_q;
  assign modal_state_o[MS_TOOLCHG]  = toolChg_q;

endmodule

// File: tb/tb_gcode_modal_sequencer.sv
// Randomized bench for gcode_modal_sequencer with a behavioural model of
// the modal state, position tracking and handshakes.
module tb_gcode_modal_sequencer;

  localparam logic [3:0] C_G00 = 4'd0;
  localparam logic [3:0] C_G01 = 4'd1;
  localparam logic [3:0] C_G20 = 4'd2;
  localparam logic [3:0] C_G21 = 4'd3;
  localparam logic [3:0] C_G90 = 4'd4;
  localparam logic [3:0] C_G91 = 4'd5;
  localparam logic [3:0] C_M2  = 4'd6;
  localparam logic [3:0] C_M6  = 4'd7;
  localparam logic [3:0] C_M72 = 4'd8;

  logic               clk;
  logic               rst_n;
  logic               cmdValid;
  logic               cmdReady;
  logic [3:0]         cmdCode;
  logic signed [15:0] cmdX;
  logic signed [15:0] cmdY;
  logic               mvValid;
  logic               mvReady;
  logic               mvLinear;
  logic               mvPenUp;
  logic signed [19:0] mvX;
  logic signed [19:0] mvY;
  logic               toolReq;
  logic               toolAck;
  logic [4:0]         modalState;
  logic               halted;
  logic               err;

  int compareCount = 0;
  int failCount    = 0;

  bit mLinear, mInches, mAbs, mRaise, mToolChg, mErr;
  int mPosX, mPosY;
  int expX, expY;
  bit expLinear, expPenUp;

  gcode_modal_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady), .cmd_code_i(cmdCode),
    .cmd_x_i(cmdX), .cmd_y_i(cmdY),
    .mv_valid_o(mvValid), .mv_ready_i(mvReady), .mv_linear_o(mvLinear),
    .mv_pen_up_o(mvPenUp), .mv_x_o(mvX), .mv_y_o(mvY),
    .tool_req_o(toolReq), .tool_ack_i(toolAck),
    .modal_state_o(modalState), .halted_o(halted), .err_o(err)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input int actual, input int expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int expModal();
    return {27'd0, mToolChg, mRaise, mAbs, mInches, mLinear};
  endfunction

  function automatic void modelReset();
    mLinear = 0; mInches = 0; mAbs = 1; mRaise = 0; mToolChg = 0; mErr = 0;
    mPosX = 0; mPosY = 0;
  endfunction

  // Target in 0.01 mm: inch operands scaled by 813/32 rounded toward -inf
  function automatic int calcTarget(input int op, input int pos, output bit sat);
    longint p, v, t;
    if (mInches) begin
      p = longint'(op) * 813;
      v = p / 32;
      if (p < 0 && (p % 32) != 0) v = v - 1;
    end else begin
      v = op;
    end
    t = mAbs ? v : longint'(pos) + v;
    sat = 0;
    if (t > 524287) begin t = 524287; sat = 1; end
    else if (t < -524288) begin t = -524288; sat = 1; end
    return int'(t);
  endfunction

  function automatic void modelAccept(input logic [3:0] code, input int x, input int y);
    bit sx, sy;
    case (code)
      C_G20: mInches = 1;
      C_G21: mInches = 0;
      C_G90: mAbs = 1;
      C_G91: mAbs = 0;
      C_M72: mRaise = 1;
      C_M6:  mToolChg = 1;
      C_M2:  ;
      C_G00, C_G01: begin
        mLinear = (code == C_G01);
        mToolChg = 0;
        expX = calcTarget(x, mPosX, sx);
        expY = calcTarget(y, mPosY, sy);
        mPosX = expX; mPosY = expY;
        if (sx || sy) mErr = 1;
        expLinear = mLinear;
        expPenUp = mRaise;
      end
      default: mErr = 1;
    endcase
  endfunction

  // Present one command, wait (bounded) for acceptance, update the model
  task automatic applyStimulus(input logic [3:0] code, input int x, input int y);
    int waitCnt;
    waitCnt = 0;
    cmdValid = 1; cmdCode = code; cmdX = 16'(x); cmdY = 16'(y);
    while (!cmdReady && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!cmdReady) begin
      checkOutput("accept_timeout", 0, 1);
      cmdValid = 0;
      return;
    end
    @(negedge clk);
    cmdValid = 0;
    modelAccept(code, x, y);
    checkOutput("modal", modalState, expModal());
  endtask

  // Called one cycle after a move is accepted: check latency, payload,
  // stability while stalled, and the return to idle
  task automatic checkMove(input int hold);
    checkOutput("mv_valid_early", mvValid, 0);
    @(negedge clk);
    checkOutput("mv_valid", mvValid, 1);
    checkOutput("mv_x", int'(mvX), expX);
    checkOutput("mv_y", int'(mvY), expY);
    checkOutput("mv_linear", mvLinear, expLinear);
    checkOutput("mv_pen_up", mvPenUp, expPenUp);
    checkOutput("cmd_ready_busy", cmdReady, 0);
    checkOutput("err", err, mErr);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("mv_valid_hold", mvValid, 1);
      checkOutput("mv_x_hold", int'(mvX), expX);
      checkOutput("mv_y_hold", int'(mvY), expY);
    end
    mvReady = 1;
    @(negedge clk);
    mvReady = 0;
    mRaise = 0;
    checkOutput("mv_valid_done", mvValid, 0);
    checkOutput("cmd_ready_done", cmdReady, 1);
    checkOutput("modal_done", modalState, expModal());
  endtask

  // Called right after M6 is accepted
  task automatic doTool(input int waitCycles);
    checkOutput("tool_req", toolReq, 1);
    checkOutput("cmd_ready_tool", cmdReady, 0);
    for (int i = 0; i < waitCycles; i++) begin
      @(negedge clk);
      checkOutput("tool_req_hold", toolReq, 1);
    end
    toolAck = 1;
    @(negedge clk);
    toolAck = 0;
    mToolChg = 0;
    checkOutput("tool_req_done", toolReq, 0);
    checkOutput("cmd_ready_tool_done", cmdReady, 1);
    checkOutput("modal_tool_done", modalState, expModal());
  endtask

  task automatic doReset();
    rst_n = 0; cmdValid = 0; mvReady = 0; toolAck = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    modelReset();
    @(negedge clk);
  endtask

  // Main sequence: directed cases, random traffic, error and reset cases
  initial begin
    int r, x, y;
    logic [3:0] code;
    rst_n = 0; cmdValid = 0; cmdCode = 0; cmdX = 0; cmdY = 0;
    mvReady = 0; toolAck = 0;
    doReset();
    checkOutput("rst_cmd_ready", cmdReady, 1);
    checkOutput("rst_mv_valid", mvValid, 0);
    checkOutput("rst_modal", modalState, 5'b00100);
    checkOutput("rst_mv_x", int'(mvX), 0);
    checkOutput("rst_tool_req", toolReq, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_err", err, 0);

    applyStimulus(C_G01, 100, -50);
    checkMove(3);
    checkOutput("g01_x_const", int'(mvX), 100);
    checkOutput("g01_y_const", int'(mvY), -50);

    doReset();
    applyStimulus(C_G91, 0, 0);
    applyStimulus(C_G00, 10, 10);
    checkMove(0);
    applyStimulus(C_G00, 10, 10);
    checkMove(1);
    checkOutput("rel_x_const", int'(mvX), 20);
    checkOutput("abs_bit", modalState[2], 0);

    applyStimulus(C_G90, 0, 0);
    applyStimulus(C_G20, 0, 0);
    applyStimulus(C_G01, 100, 0);
    checkMove(0);
    checkOutput("inch_pos_const", int'(mvX), 2540);
    applyStimulus(C_G01, -100, 0);
    checkMove(0);
    checkOutput("inch_neg_const", int'(mvX), -2541);
    applyStimulus(C_G21, 0, 0);

    mvReady = 1;
    @(negedge clk);
    mvReady = 0;
    applyStimulus(C_M72, 0, 0);
    applyStimulus(C_G00, 5, 5);
    checkMove(2);
    applyStimulus(C_G00, 6, 6);
    checkMove(0);

    toolAck = 1;
    @(negedge clk);
    toolAck = 0;
    checkOutput("ack_ignored_ready", cmdReady, 1);
    applyStimulus(C_M6, 0, 0);
    doTool(10);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 1) == 1) begin
        x = $urandom_range(0, 65535) - 32768;
        y = $urandom_range(0, 65535) - 32768;
      end else begin
        x = $urandom_range(0, 4000) - 2000;
        y = $urandom_range(0, 4000) - 2000;
      end
      if (r < 40) begin
        code = ($urandom_range(0, 1) == 1) ? C_G01 : C_G00;
        applyStimulus(code, x, y);
        checkMove($urandom_range(0, 3));
      end else if (r < 80) begin
        code = 4'($urandom_range(2, 5));
        applyStimulus(code, 0, 0);
      end else if (r < 90) begin
        applyStimulus(C_M72, 0, 0);
      end else if (r < 96) begin
        applyStimulus(C_M6, 0, 0);
        doTool($urandom_range(0, 5));
      end else begin
        code = 4'($urandom_range(9, 15));
        applyStimulus(code, x, y);
        checkOutput("rand_err", err, 1);
      end
    end

    doReset();
    applyStimulus(C_G91, 0, 0);
    for (int n = 0; n < 18; n++) begin
      applyStimulus(C_G01, 32767, 0);
      checkMove(0);
    end
    checkOutput("sat_x_const", int'(mvX), 524287);
    checkOutput("sat_err", err, 1);

    doReset();
    applyStimulus(4'd15, 1, 1);
    checkOutput("bad_code_err", err, 1);
    checkOutput("bad_code_no_move", mvValid, 0);
    checkOutput("bad_code_ready", cmdReady, 1);

    applyStimulus(C_G01, 1, 2);
    @(negedge clk);
    checkOutput("pre_rst_mv_valid", mvValid, 1);
    #2 rst_n = 0;
    #1;
    checkOutput("async_rst_mv_valid", mvValid, 0);
    checkOutput("async_rst_ready", cmdReady, 1);
    checkOutput("async_rst_modal", modalState, 5'b00100);
    checkOutput("async_rst_err", err, 0);
    @(negedge clk);
    rst_n = 1;
    modelReset();
    @(negedge clk);

    applyStimulus(C_M6, 0, 0);
    #2 rst_n = 0;
    #1;
    checkOutput("async_rst_tool_req", toolReq, 0);
    @(negedge clk);
    rst_n = 1;
    modelReset();
    @(negedge clk);

    applyStimulus(C_M2, 0, 0);
    checkOutput("halted", halted, 1);
    checkOutput("halt_ready", cmdReady, 0);
    cmdValid = 1; cmdCode = C_G01; cmdX = 16'd7; cmdY = 16'd7;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("halt_ready_hold", cmdReady, 0);
      checkOutput("halt_no_move", mvValid, 0);
    end
    cmdValid = 0;
    checkOutput("halt_modal", modalState, expModal());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
